// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift_seq controller and the lss_reg command bus.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        C_STORE = 2'b00,
        C_SHL   = 2'b01,
        C_LOAD  = 2'b10,
        C_SHR   = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    function automatic cmd_e shift_cmd(input op_e op);
        return (op == OP_SLL || op == OP_ROL) ? C_SHL : C_SHR;
    endfunction

endpackage

// File: rtl/lss_reg.sv
// Load/store/shift register: c selects store, shift left, load or shift right.
module lss_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [1:0]   c,
    input  logic [N-1:0] in,
    output logic [N-1:0] out
);
    logic [N-1:0] out_q;

    // Shift-in bit comes from the edge of the parallel input nearest the vacated end.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            out_q <= '0;
        end else begin
            case (c)
                2'b01:   out_q <= {out_q[N-2:0], in[0]};
                2'b10:   out_q <= in;
                2'b11:   out_q <= {in[N-1], out_q[N-1:1]};
                default: out_q <= out_q;
            endcase
        end
    end

    assign out = out_q;

endmodule

// File: rtl/shift_seq_cnt.sv
// Loadable SW-bit down-counter used to pace shift_seq iterations.
module shift_cnt #(
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          en,
    input  logic [SW-1:0] d,
    output logic [SW-1:0] q,
    output logic          is_one
);
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = d;
        end else if (en) begin
            cnt_d = cnt_q - SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q      = cnt_q;
    assign is_one = (cnt_q == SW'(1));

endmodule

// File: rtl/shift_seq.sv
// Sequencer turning one lss_reg into an iterative multi-bit shifter/rotator.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [SW-1:0] amt,
    input  logic [N-1:0]  din,
    input  logic          flush,
    input  logic [N-1:0]  reg_q,
    output logic [N-1:0]  reg_d,
    output logic [1:0]    reg_c,
    output logic          reg_clr_n,
    output logic          busy,
    output logic          done
);
    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic          sign_q, sign_d;
    logic          cnt_ld, cnt_en, cnt_is_one;
    logic [SW-1:0] cnt_q;
    logic          fill;

    shift_cnt #(.SW(SW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .ld     (cnt_ld),
        .en     (cnt_en),
        .d      (amt),
        .q      (cnt_q),
        .is_one (cnt_is_one)
    );

    always_comb begin
        case (op_q)
            OP_SRA:  fill = sign_q;
            OP_ROL:  fill = reg_q[N-1];
            default: fill = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sign_d    = sign_q;
        reg_c     = C_STORE;
        reg_d     = din;
        reg_clr_n = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        cnt_ld    = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    reg_clr_n = 1'b0;
                end else if (start) begin
                    reg_c   = C_LOAD;
                    cnt_ld  = 1'b1;
                    op_d    = op_e'(op);
                    sign_d  = din[N-1];
                    state_d = (amt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (flush) begin
                    reg_clr_n = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    reg_c  = shift_cmd(op_q);
                    reg_d  = {N{fill}};
                    cnt_en = (cnt_q != '0);
                    if (cnt_is_one) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy    = 1'b1;
                state_d = S_IDLE;
                if (flush) begin
                    reg_clr_n = 1'b0;
                end else begin
                    done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Reset overrides the bus so the register clears alongside the controller.
        if (rst) begin
            reg_c     = C_STORE;
            reg_clr_n = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
            cnt_ld    = 1'b0;
            cnt_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

endmodule
